fp_signinj_pipe: RTL and testbench

Parametrised, pipelined successor to the double-precision sign-injection unit. Performs FSGNJ/FSGNJN/FSGNJX on single or double operands in a FLEN-wide FP register format, with RISC-V NaN-boxing of single results. Sits in the FP ALU datapath behind the issue stage. Uses a valid/ready handshake with per-stage backpressure and carries a tag for writeback.

---
 rtl/fp_signinj_pipe.sv | 141 ++++++++++++++
 tb/tb_fp_signinj_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_signinj_pipe.sv
// fp_signinj_pipe: pipelined FSGNJ / FSGNJN / FSGNJX for single or double
// operands held in a FLEN-wide FP register, with NaN-boxed single results.
// Sign injection happens combinationally ahead of stage 0. The remaining
// stages only carry the result and its tag forward under valid/ready flow
// control.
// Optional build macro: FP_SIGNINJ_NANBOX_CHECK_EN (FLEN=64 only). When it is
// defined, a single-precision operand whose upper word is not all ones is
// replaced by the canonical NaN before its sign is used.
module fp_signinj_pipe #(
  parameter int FLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLEN-1:0]  in_a,
  input  logic [FLEN-1:0]  in_b,
  input  logic [1:0]       in_op,
  input  logic             in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // Operand b supplies only its sign bit. The rest of b is deliberately dropped.
  logic unused_b;
  assign unused_b = ^in_b;

  // Op 11 is reserved and falls back to plain FSGNJ.
  function automatic logic sign_sel(input logic [1:0] op, input logic sa, input logic sb);
    case (op)
      2'b01:   return ~sb;
      2'b10:   return sa ^ sb;
      default: return sb;
    endcase
  endfunction

  logic [FLEN-1:0] result_c;

  generate
    if (FLEN == 64) begin : g_flen64
      logic [31:0] a_sp;
      logic [31:0] b_sp;

      // Pick the single-precision view of each operand, with optional unboxed-NaN substitution.
      always_comb begin
`ifdef FP_SIGNINJ_NANBOX_CHECK_EN
        a_sp = (in_a[63:32] == 32'hFFFF_FFFF) ? in_a[31:0] : 32'h7FC0_0000;
        b_sp = (in_b[63:32] == 32'hFFFF_FFFF) ? in_b[31:0] : 32'h7FC0_0000;
`else
        a_sp = in_a[31:0];
        b_sp = in_b[31:0];
`endif
      end

      // Build the result. A single-precision result is NaN-boxed into the upper word.
      always_comb begin
        if (in_fmt) begin
          result_c = {sign_sel(in_op, in_a[63], in_b[63]), in_a[62:0]};
        end else begin
          result_c = {32'hFFFF_FFFF, sign_sel(in_op, a_sp[31], b_sp[31]), a_sp[30:0]};
        end
      end
    end else begin : g_flen32
      // A 32-bit register only ever holds singles, so the format input does not matter.
      logic unused_fmt;
      assign unused_fmt = in_fmt;

      // Single-precision sign injection.
      always_comb begin
        result_c = {sign_sel(in_op, in_a[31], in_b[31]), in_a[30:0]};
      end
    end
  endgenerate

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] advance;
  logic [FLEN-1:0]   data_q [STAGES];
  logic [FLEN-1:0]   data_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];

  // Resolve backpressure from the output towards stage 0. A stage can accept
  // a beat when it is empty or when its own beat is leaving this cycle.
  always_comb begin
    logic rdy;
    advance = '0;
    rdy     = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      advance[i] = valid_q[i] & rdy;
      rdy        = ~valid_q[i] | advance[i];
    end
    in_ready = rdy;
  end

  // Next-state logic. Data and tag registers change only when a beat actually moves into them.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d[0] = (in_valid & in_ready) | (valid_q[0] & ~advance[0]);
    if (in_valid && in_ready) begin
      data_d[0] = result_c;
      tag_d[0]  = in_tag;
    end
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = advance[i-1] | (valid_q[i] & ~advance[i]);
      if (advance[i-1]) begin
        data_d[i] = data_q[i-1];
        tag_d[i]  = tag_q[i-1];
      end
    end
  end

  // Stage registers. Reset drops any beat that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid  = valid_q[STAGES-1];
  assign out_result = data_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];
  assign busy       = |valid_q;

endmodule

// File: tb/tb_fp_signinj_pipe.sv
// Bench for fp_signinj_pipe: directed cases plus randomized traffic against a
// spec-level reference model and an in-order scoreboard. Two instances are
// used: FLEN=64/STAGES=2 and FLEN=32/STAGES=1.
module tb_fp_signinj_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, in_fmt, out_valid, out_ready, busy;
  logic [63:0] in_a, in_b, out_result;
  logic [1:0]  in_op;
  logic [4:0]  in_tag, out_tag;

  logic        in32_valid, in32_ready, in32_fmt, out32_valid, out32_ready, busy32;
  logic [31:0] in32_a, in32_b, out32_result;
  logic [1:0]  in32_op;
  logic [4:0]  in32_tag, out32_tag;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t q32[$];
  logic [63:0] cur_exp;
  logic [31:0] cur_exp32;
  bit          lat_chk   = 0;
  bit          lat_chk32 = 0;
  bit          done      = 0;
  bit          done32    = 0;

  fp_signinj_pipe #(.FLEN(64), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_fmt(in_fmt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  fp_signinj_pipe #(.FLEN(32), .STAGES(1), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in32_valid), .in_ready(in32_ready),
    .in_a(in32_a), .in_b(in32_b), .in_op(in32_op), .in_fmt(in32_fmt), .in_tag(in32_tag),
    .out_valid(out32_valid), .out_ready(out32_ready),
    .out_result(out32_result), .out_tag(out32_tag), .busy(busy32)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk_eq(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: the sign comes from the rule for the op, and the magnitude comes from a.
  function automatic logic ref_sign(input logic [1:0] op, input logic sa, input logic sb);
    if (op == 2'd1) return !sb;
    if (op == 2'd2) return sa != sb;
    return sb;
  endfunction

  function automatic logic [63:0] model64(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op, input logic fmt);
    logic [31:0] as, bs;
    if (fmt) return {ref_sign(op, a[63], b[63]), a[62:0]};
    as = a[31:0];
    bs = b[31:0];
`ifdef FP_SIGNINJ_NANBOX_CHECK_EN
    if (a[63:32] != 32'hFFFFFFFF) as = 32'h7FC00000;
    if (b[63:32] != 32'hFFFFFFFF) bs = 32'h7FC00000;
`endif
    return {32'hFFFFFFFF, ref_sign(op, as[31], bs[31]), as[30:0]};
  endfunction

  function automatic logic [31:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    return {ref_sign(op, a[31], b[31]), a[30:0]};
  endfunction

  // Scoreboard and handshake monitor for the 64-bit instance, sampled mid-cycle.
  logic        stall_prev = 0;
  logic [63:0] prev_res;
  logic [4:0]  prev_tag;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      stall_prev = 0;
    end else begin
      chk_eq("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
      if (stall_prev) begin
        chk_eq("stall_hold_valid", 64'(out_valid), 64'd1);
        chk_eq("stall_hold_result", out_result, prev_res);
        chk_eq("stall_hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid && out_ready) begin
        chk_eq("out_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk_eq("result", out_result, e.res);
          chk_eq("tag", 64'(out_tag), 64'(e.tag));
          if (lat_chk) chk_eq("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_res   = out_result;
      prev_tag   = out_tag;
      if (in_valid && in_ready) q.push_back('{cur_exp, in_tag, cyc});
    end
  end

  // Same monitor for the FLEN=32, single-stage instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q32.delete();
    end else begin
      chk_eq("in32_ready", 64'(in32_ready), 64'((q32.size() < 1) || out32_ready));
      if (out32_valid && out32_ready) begin
        chk_eq("out32_expected", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          chk_eq("result32", 64'(out32_result), e.res);
          chk_eq("tag32", 64'(out32_tag), 64'(e.tag));
          if (lat_chk32) chk_eq("latency32", 64'(cyc - e.cyc), 64'd1);
        end
      end
      if (in32_valid && in32_ready) q32.push_back('{64'(cur_exp32), in32_tag, cyc});
    end
  end

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                       input logic fmt, input logic [4:0] tag, input logic [63:0] expv);
    int n = 0;
    in_a = a; in_b = b; in_op = op; in_fmt = fmt; in_tag = tag; cur_exp = expv;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk_eq("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_tag = 5'($urandom);
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic fmt, input logic [4:0] tag, input logic [31:0] expv);
    int n = 0;
    in32_a = a; in32_b = b; in32_op = op; in32_fmt = fmt; in32_tag = tag; cur_exp32 = expv;
    in32_valid = 1;
    @(negedge clk);
    while (!in32_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in32_ready) chk_eq("accept32_timeout", 64'(in32_ready), 64'd1);
    @(posedge clk);
    #1;
    in32_valid = 0;
    in32_a = $urandom;
    in32_b = $urandom;
  endtask

  task automatic rand_drive(input logic [4:0] tag);
    logic [63:0] a, b;
    logic [1:0]  op;
    logic        fmt;
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    op  = 2'($urandom_range(0, 3));
    fmt = 1'($urandom_range(0, 1));
    if (!fmt && $urandom_range(0, 3) != 0) a[63:32] = 32'hFFFFFFFF;
    if (!fmt && $urandom_range(0, 3) != 0) b[63:32] = 32'hFFFFFFFF;
    drive(a, b, op, fmt, tag, model64(a, b, op, fmt));
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q32.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain_empty", 64'(q.size()), 64'd0);
    chk_eq("drain32_empty", 64'(q32.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; in_op = '0; in_fmt = 0; in_tag = '0;
    out_ready = 1;
    in32_valid = 0; in32_a = '0; in32_b = '0; in32_op = '0; in32_fmt = 0; in32_tag = '0;
    out32_ready = 1;
    repeat (3) @(negedge clk);
    chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_out_result", out_result, 64'd0);
    chk_eq("rst_out_tag", 64'(out_tag), 64'd0);
    chk_eq("rst_out32_valid", 64'(out32_valid), 64'd0);
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Double-precision ops issued back to back: 2-cycle latency, tags preserved.
    lat_chk = 1;
    drive(64'h3FF0000000000000, 64'hC000000000000000, 2'b00, 1, 5'd1, 64'hBFF0000000000000);
    drive(64'h3FF0000000000000, 64'hC000000000000000, 2'b01, 1, 5'd2, 64'h3FF0000000000000);
    drive(64'h3FF0000000000000, 64'hC000000000000000, 2'b10, 1, 5'd3, 64'hBFF0000000000000);
    drain();
    lat_chk = 0;

    // Boxed single operands, and reserved op 11 behaving as FSGNJ.
    drive(64'hFFFFFFFF3F800000, 64'hFFFFFFFFC0000000, 2'b00, 0, 5'd4, 64'hFFFFFFFFBF800000);
    drive(64'hFFFFFFFF3F800000, 64'hFFFFFFFFC0000000, 2'b11, 0, 5'd5, 64'hFFFFFFFFBF800000);
    // Unboxed single a.
`ifdef FP_SIGNINJ_NANBOX_CHECK_EN
    drive(64'h000000003F800000, 64'hFFFFFFFFC0000000, 2'b00, 0, 5'd6, 64'hFFFFFFFFFFC00000);
`else
    drive(64'h000000003F800000, 64'hFFFFFFFFC0000000, 2'b00, 0, 5'd6, 64'hFFFFFFFFBF800000);
`endif
    drain();

    // Backpressure: six beats streamed while the output stalls for six cycles.
    fork
      begin
        for (int t = 1; t <= 6; t++) rand_drive(5'(t));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();

    // FLEN=32, single stage: the format input is ignored.
    lat_chk32 = 1;
    drive32(32'h40490FDB, 32'h80000000, 2'b10, 1, 5'd7, 32'hC0490FDB);
    drain();
    lat_chk32 = 0;

    // Randomized traffic on both instances with random output stalls.
    done = 0;
    done32 = 0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          rand_drive(5'(k));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int k = 0; k < 150; k++) begin
          logic [31:0] a, b;
          logic [1:0]  op;
          a  = $urandom;
          b  = $urandom;
          op = 2'($urandom_range(0, 3));
          drive32(a, b, op, 1'($urandom_range(0, 1)), 5'(k), model32(a, b, op));
        end
        done32 = 1;
      end
      begin
        while (!done32) begin
          @(posedge clk);
          #1 out32_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1;
    out32_ready = 1;
    drain();

    // Asynchronous reset while two beats are held in the pipeline.
    out_ready = 0;
    rand_drive(5'd20);
    rand_drive(5'd21);
    #2;
    chk_eq("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 0;
    #1;
    chk_eq("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk_eq("async_rst_busy", 64'(busy), 64'd0);
    chk_eq("async_rst_out_result", out_result, 64'd0);
    chk_eq("async_rst_out_tag", 64'(out_tag), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    out_ready = 1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || busy) cnt++;
    end
    chk_eq("post_reset_stale", 64'(cnt), 64'd0);
    chk_eq("post_reset_in_ready", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
